// File: rtl/decoder_3_8_behavioal.sv
// Registered 3-to-8 decoder with valid qualifier and change-detect pulse.
// Build option: define DECODER_3_8_ACTLOW_EN for active-low Y (idle 8'hFF);
// left undefined, Y is active-high (idle 8'h00). valid/chg are always active-high.
module decoder_3_8_behavioal (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [2:0] D,
  output logic [7:0] Y,
  output logic       valid,
  output logic       chg
);

  localparam int unsigned SEL_W = 3;
  localparam int unsigned OUT_W = 1 << SEL_W;

`ifdef DECODER_3_8_ACTLOW_EN
  localparam logic [OUT_W-1:0] IDLE = '1;
`else
  localparam logic [OUT_W-1:0] IDLE = '0;
`endif

  // Retained record of the most recent enabled capture
  logic [SEL_W-1:0] last_d;
  logic             last_v;

  logic [OUT_W-1:0] y_nxt;
  logic             valid_nxt;
  logic             chg_nxt;
  logic [SEL_W-1:0] last_d_nxt;
  logic             last_v_nxt;

  // One-hot (or one-cold) decode of a select code in the configured polarity
  function automatic logic [OUT_W-1:0] decode(input logic [SEL_W-1:0] sel);
    logic [OUT_W-1:0] hot;
    hot = OUT_W'(1) << sel;
`ifdef DECODER_3_8_ACTLOW_EN
    return ~hot;
`else
    return hot;
`endif
  endfunction

  // Next-state: decode when enabled, otherwise idle while keeping the capture history
  always_comb begin
    y_nxt      = IDLE;
    valid_nxt  = 1'b0;
    chg_nxt    = 1'b0;
    last_d_nxt = last_d;
    last_v_nxt = last_v;
    if (en) begin
      y_nxt      = decode(D);
      valid_nxt  = 1'b1;
      chg_nxt    = !last_v || (D != last_d);
      last_d_nxt = D;
      last_v_nxt = 1'b1;
    end
  end

  // Output and history registers; reset discards the held decode immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Y      <= IDLE;
      valid  <= 1'b0;
      chg    <= 1'b0;
      last_d <= '0;
      last_v <= 1'b0;
    end else begin
      Y      <= y_nxt;
      valid  <= valid_nxt;
      chg    <= chg_nxt;
      last_d <= last_d_nxt;
      last_v <= last_v_nxt;
    end
  end

endmodule

// File: tb/tb_decoder_3_8_behavioal.sv
// Self-checking bench for decoder_3_8_behavioal: directed scenarios plus
// randomized en/D traffic compared against a behavioural model.
`timescale 1ns/1ps
module tb_decoder_3_8_behavioal;

  logic       clk;
  logic       clk_run;
  logic       rst_n;
  logic       en;
  logic [2:0] D;
  logic [7:0] Y;
  logic       valid;
  logic       chg;

  int n_tests;
  int n_fail;

  // Model state: history of the last enabled capture
  int m_last_d;
  bit m_last_v;

  logic [7:0] exp_y;
  logic       exp_valid;
  logic       exp_chg;

  decoder_3_8_behavioal dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .D     (D),
    .Y     (Y),
    .valid (valid),
    .chg   (chg)
  );

  // Gated clock so the reset check can run with no clock edges
  initial clk = 1'b0;
  always #5 clk = clk_run ? ~clk : clk;

  // Model: idle value of Y in the built polarity
  function automatic logic [7:0] idle_val();
`ifdef DECODER_3_8_ACTLOW_EN
    return 8'hFF;
`else
    return 8'h00;
`endif
  endfunction

  // Model: line d is 2**d; active-low build is its complement within 8 bits
  function automatic logic [7:0] model_decode(input int d);
    int v;
    v = 2 ** d;
`ifdef DECODER_3_8_ACTLOW_EN
    v = 255 - v;
`endif
    return 8'(v);
  endfunction

  // Single comparison point: count and report
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus, update the model, and check after the edge
  task automatic step(input bit e, input int d, input string tag);
    en = e;
    D  = 3'(d);
    @(posedge clk);
    exp_valid = e;
    exp_chg   = e && (!m_last_v || d != m_last_d);
    exp_y     = e ? model_decode(d) : idle_val();
    if (e) begin
      m_last_d = d;
      m_last_v = 1'b1;
    end
    @(negedge clk);
    check({tag, ".y"},     32'(Y),     32'(exp_y));
    check({tag, ".valid"}, 32'(valid), 32'(exp_valid));
    check({tag, ".chg"},   32'(chg),   32'(exp_chg));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".y"},     32'(Y),     32'(idle_val()));
    check({tag, ".valid"}, 32'(valid), 32'd0);
    check({tag, ".chg"},   32'(chg),   32'd0);
  endtask

  initial begin
    int ones;
    n_tests  = 0;
    n_fail   = 0;
    m_last_d = 0;
    m_last_v = 1'b0;
    clk_run  = 1'b0;
    rst_n    = 1'b1;
    en       = 1'b0;
    D        = 3'd0;

    // Asynchronous reset with the clock stopped
    #2 rst_n = 1'b0;
    #1 check_reset_state("reset");
    #2 rst_n = 1'b1;
    clk_run = 1'b1;
    @(negedge clk);

    // Full sweep: every code decodes, each capture is a change
    for (int d = 0; d < 8; d++) step(1'b1, d, $sformatf("sweep%0d", d));

    // Directed polarity spot checks against fixed values
`ifdef DECODER_3_8_ACTLOW_EN
    step(1'b1, 2, "lit2");
    check("lit2.const", 32'(Y), 32'h0000_00FB);
    step(1'b1, 7, "lit7");
    check("lit7.const", 32'(Y), 32'h0000_007F);
`else
    step(1'b1, 2, "lit2");
    check("lit2.const", 32'(Y), 32'h0000_0004);
    step(1'b1, 7, "lit7");
    check("lit7.const", 32'(Y), 32'h0000_0080);
`endif

    // Hold: chg only on the first of repeated captures
    step(1'b1, 5, "hold0");
    step(1'b1, 5, "hold1");
    step(1'b1, 5, "hold2");
    // Gap does not re-arm chg
    step(1'b0, 5, "gap");
    step(1'b1, 5, "rearm");
    check("rearm.chg_lo", 32'(chg), 32'd0);

    // Mid-run reset discards the held decode and the history
    step(1'b1, 7, "pre_rst");
    #1 rst_n = 1'b0;
    #1 check_reset_state("mid_rst");
    m_last_d = 0;
    m_last_v = 1'b0;
    #1 rst_n = 1'b1;
    step(1'b1, 0, "post_rst");
    check("post_rst.chg_hi", 32'(chg), 32'd1);

    // Randomized traffic with a one-hot / one-cold property check
    for (int i = 0; i < 1000; i++) begin
      step(($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)), $sformatf("rnd%0d", i));
      if (valid) begin
`ifdef DECODER_3_8_ACTLOW_EN
        ones = $countones(~Y);
`else
        ones = $countones(Y);
`endif
        check($sformatf("rnd%0d.onehot", i), 32'(ones), 32'd1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global guard against a stalled run
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got %0d tests expected completion", n_tests);
    $fatal(1, "timeout");
  end

endmodule
